// File: rtl/rdata_pkg.sv
// rtl/rdata_pkg.sv - shared transaction status codes for the read-data interconnect
package rdata_pkg;

  localparam int STAT_BITS = 2;

  typedef enum logic [STAT_BITS-1:0] {
    NO_REQ = 2'd0,
    WAIT   = 2'd1,
    W_ACK  = 2'd2,
    W_DATA = 2'd3
  } rd_stat_e;

  function automatic logic is_w_data(input logic [STAT_BITS-1:0] stat);
    return stat == W_DATA;
  endfunction

endpackage

// File: rtl/rdata_capture_reg.sv
// rtl/rdata_capture_reg.sv - per-master qualify compare, read-data register and valid strobe
module rdata_capture_reg
  import rdata_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int STAT_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              slave,
  input  logic              s_no,
  input  logic [STAT_W-1:0] stat,
  input  logic              sel,
  input  logic [DATA_W-1:0] rdata_in,
  output logic              qual,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid
);

  logic take;

  // Only the data phase for this slave counts; queued or pending-ack states never capture.
  assign qual = (slave == s_no) && (stat == STAT_W'(W_DATA));
  assign take = qual && sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= take;
      if (take) begin
        rdata <= rdata_in;
      end
    end
  end

endmodule

// File: rtl/rdata_seeker.sv
// rtl/rdata_seeker.sv - steers slave read data into two per-master capture registers
module rdata_seeker
  import rdata_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int STAT_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              slave0,
  input  logic              slave1,
  input  logic [STAT_W-1:0] stat0,
  input  logic [STAT_W-1:0] stat1,
  input  logic [DATA_W-1:0] rdata_in,
  input  logic              s_no,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              rvalid0,
  output logic              rvalid1
);

  logic qual0;
  logic qual1;
  logic sel1;

  // Master 0 wins when both claim the same data beat.
  assign sel1 = ~qual0;

  rdata_capture_reg #(
    .DATA_W(DATA_W),
    .STAT_W(STAT_W)
  ) u_cap0 (
    .clk      (clk),
    .rst      (rst),
    .slave    (slave0),
    .s_no     (s_no),
    .stat     (stat0),
    .sel      (1'b1),
    .rdata_in (rdata_in),
    .qual     (qual0),
    .rdata    (rdata0),
    .rvalid   (rvalid0)
  );

  rdata_capture_reg #(
    .DATA_W(DATA_W),
    .STAT_W(STAT_W)
  ) u_cap1 (
    .clk      (clk),
    .rst      (rst),
    .slave    (slave1),
    .s_no     (s_no),
    .stat     (stat1),
    .sel      (sel1),
    .rdata_in (rdata_in),
    .qual     (qual1),
    .rdata    (rdata1),
    .rvalid   (rvalid1)
  );

endmodule

// File: tb/tb_rdata_seeker.sv
// tb/tb_rdata_seeker.sv - directed vector bench for rdata_seeker
module tb_rdata_seeker;

  localparam logic [1:0] S_NO_REQ = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_W_ACK  = 2'd2;
  localparam logic [1:0] S_W_DATA = 2'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic        slave0;
  logic        slave1;
  logic [1:0]  stat0;
  logic [1:0]  stat1;
  logic [31:0] rdata_in;
  logic        s_no;
  logic [31:0] rdata0;
  logic [31:0] rdata1;
  logic        rvalid0;
  logic        rvalid1;

  int total = 0;
  int bad   = 0;

  rdata_seeker #(.DATA_W(32), .STAT_W(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .slave0   (slave0),
    .slave1   (slave1),
    .stat0    (stat0),
    .stat1    (stat1),
    .rdata_in (rdata_in),
    .s_no     (s_no),
    .rdata0   (rdata0),
    .rdata1   (rdata1),
    .rvalid0  (rvalid0),
    .rvalid1  (rvalid1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        s_no;
    logic        slave0;
    logic [1:0]  stat0;
    logic        slave1;
    logic [1:0]  stat1;
    logic [31:0] din;
    logic [31:0] e_r0;
    logic [31:0] e_r1;
    logic        e_v0;
    logic        e_v1;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic sn, input logic sl0, input logic [1:0] st0,
                       input logic sl1, input logic [1:0] st1, input logic [31:0] d);
    @(negedge clk);
    rst = r; s_no = sn; slave0 = sl0; stat0 = st0; slave1 = sl1; stat1 = st1; rdata_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [31:0] r0, input logic [31:0] r1,
                           input logic v0, input logic v1);
    check({tag, " rdata0"}, rdata0, r0);
    check({tag, " rdata1"}, rdata1, r1);
    check({tag, " rvalid0"}, {31'd0, rvalid0}, {31'd0, v0});
    check({tag, " rvalid1"}, {31'd0, rvalid1}, {31'd0, v1});
  endtask

  initial begin
    rst = 1'b1; s_no = 1'b0; slave0 = 1'b0; slave1 = 1'b0;
    stat0 = S_NO_REQ; stat1 = S_NO_REQ; rdata_in = '0;

    //         rst  sno sl0 st0       sl1 st1       din            e_r0           e_r1           v0 v1
    vecs[0]  = '{1'b1, 1'b0, 1'b0, S_NO_REQ, 1'b0, S_NO_REQ, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, S_WAIT,   1'b1, S_W_DATA, 32'h0000_000F, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, S_W_DATA, 1'b1, S_NO_REQ, 32'h0000_000F, 32'h0000_000F, 32'h0000_0000, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, S_W_DATA, 1'b1, S_W_DATA, 32'h0000_000F, 32'h0000_000F, 32'h0000_0000, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, S_W_DATA, 1'b0, S_W_DATA, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'h0000_0000, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, S_NO_REQ, 1'b0, S_W_DATA, 32'h1234_5678, 32'hA5A5_A5A5, 32'h1234_5678, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, S_W_DATA, 1'b0, S_W_DATA, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, S_NO_REQ, 1'b1, S_NO_REQ, 32'h1111_1111, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, S_WAIT,   1'b1, S_NO_REQ, 32'h2222_2222, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, S_W_ACK,  1'b1, S_NO_REQ, 32'h3333_3333, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, S_W_DATA, 1'b1, S_NO_REQ, 32'h4444_4444, 32'h4444_4444, 32'h0000_0000, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, S_W_DATA, 1'b1, S_W_DATA, 32'h5555_5555, 32'h4444_4444, 32'h5555_5555, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 1'b1, 1'b0, S_W_DATA, 1'b1, S_W_DATA, 32'h6666_6666, 32'h4444_4444, 32'h6666_6666, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 1'b1, 1'b0, S_W_DATA, 1'b1, S_W_ACK,  32'h7777_7777, 32'h4444_4444, 32'h6666_6666, 1'b0, 1'b0};

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].rst, vecs[i].s_no, vecs[i].slave0, vecs[i].stat0,
            vecs[i].slave1, vecs[i].stat1, vecs[i].din);
      check_all($sformatf("vec%0d", i), vecs[i].e_r0, vecs[i].e_r1, vecs[i].e_v0, vecs[i].e_v1);
    end

    // Reset lands on the same edge as a qualifying beat: the beat is lost.
    drive(1'b1, 1'b0, 1'b0, S_W_DATA, 1'b1, S_NO_REQ, 32'hABCD_0123);
    check_all("rst_mid", 32'h0, 32'h0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, S_W_DATA, 1'b1, S_NO_REQ, 32'hABCD_0123);
    check_all("post_rst", 32'hABCD_0123, 32'h0, 1'b1, 1'b0);

    // Data changing between edges must not reach the outputs.
    @(negedge clk);
    stat0 = S_NO_REQ;
    rdata_in = 32'hDEAD_BEEF;
    #2;
    check("no_comb rdata0", rdata0, 32'hABCD_0123);
    check("no_comb rvalid0", {31'd0, rvalid0}, 32'd1);
    @(posedge clk);
    #1;
    check_all("strobe_drop", 32'hABCD_0123, 32'h0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
